mux_rr_n: RTL and testbench
===========================

# mux_rr_n

Parametrised N:1 flit multiplexer for the router output stage, the successor of the fixed 2:1 `mux`. It locks an output to one input port for a whole packet (HEAD through TAIL) and arbitrates between packets either round-robin or by an external `sel`. Input-side ready signals provide backpressure, the output is registered, and a saturating flit counter supports link-utilisation characterisation runs.

## Interface
- `N`, 4: number of input ports (2..16).
- `DATAW`, 66: flit width. Bits `[DATAW-1:DATAW-2]` hold the flit type: NONE=2'b00, HEAD=2'b01, TAIL=2'b10, DATA=2'b11.
- `VCHW`, 2: virtual-channel field width.
- `PSELW`, `$clog2(N)`: port-select width.
- `RR_MODE`, 1: 1 selects round-robin arbitration; 0 selects external `sel`.
- `CNTW`, 16: width of the forwarded-flit counter.
- `clk`  in  1: clock, rising edge.
- `rst_`  in  1: reset, asynchronous, active-low.
- `idata`  in  N*DATAW: port k occupies `[k*DATAW +: DATAW]`.
- `ivalid`  in  N: flit present on port k.
- `ivch`  in  N*VCHW: VC per port.
- `iready`  out  N: port k's flit is consumed this cycle.
- `sel`  in  PSELW: requested port. Used only when RR_MODE=0.
- `odata`  out  DATAW: registered output flit.
- `ovalid`  out  1: registered output valid.
- `ovch`  out  VCHW: registered output VC.
- `oready`  in  1: downstream accepts `odata` this cycle.
- `cnt_clr`  in  1: synchronous clear of `fcount`.
- `fcount`  out  CNTW: number of flits forwarded, saturating.
- `oerr`  out  1: sticky protocol error.

## Operation
- FSM `IDLE` / `LOCK`, plus registers `grant` (PSELW) and `last` (PSELW).
- **IDLE**
  - Eligible port: `ivalid[k]` and type==HEAD.
  - RR_MODE=1: grant the first eligible port searching `last+1, last+2, …` modulo N.
  - RR_MODE=0: grant `sel` only if that port is eligible. A `sel` >= N grants nothing.
  - On a grant: go to `LOCK`, set `grant`. The HEAD is not consumed in the granting cycle.
- **LOCK**
  - `iready[grant] = ivalid[grant] & (~ovalid | oready)`. Every other `iready` is 0.
  - A consumed flit loads `odata`/`ovch`/`ovalid=1` on the next edge.
  - When the consumed flit's type is TAIL: return to `IDLE` and set `last <= grant`.
- Output register:
  - `oready & ovalid` with no new flit consumed: `ovalid <= 0`.
  - `odata` holds its value while `ovalid & ~oready`.
- `fcount` increments on every output transfer (`ovalid & oready`) and saturates at all-ones.
  - `cnt_clr` has priority over the increment.
- `oerr` is set, and stays set until reset, when any of these occurs:
  - a NONE flit is consumed in LOCK;
  - a HEAD flit is consumed in LOCK after the first flit of the packet.
- The flit is still forwarded when `oerr` is set.
- Ports that are not granted are never consumed. Non-HEAD flits waiting on an idle port stall until that port is granted.

## Timing
- Reset values:
  - `ovalid`=0, `odata`=0, `ovch`=0, `iready`=0.
  - `fcount`=0, `oerr`=0.
  - state=IDLE, `grant`=0, `last`=N-1, so port 0 has first priority.
- Latency:
  - Arbitration takes 1 cycle (IDLE→LOCK).
  - An input flit appears on `odata` 1 cycle after it is consumed.
  - HEAD on an idle output reaches `odata` 2 cycles after it is presented.
- Throughput is 1 flit/cycle while locked and `oready`=1.
- There is one bubble cycle between packets: the edge that consumes a TAIL returns to IDLE, and arbitration happens in the next cycle.
- Back-to-back stall: with `ovalid=1` and `oready=0`, `iready` is 0 and the output holds. A simultaneous `oready=1` and new-flit consume overwrites the register in the same cycle.
- Asserting `rst_` mid-packet immediately clears all state, per the reset values above. The upstream must restart from HEAD.
- Only TAIL closes a packet. A HEAD is always followed by at least one further flit, so there is no single-flit packet.

## Test plan
- **Single-port packet.** RR, N=4. Port 2 sends HEAD, 20 DATA, TAIL, with `oready`=1.
  - `odata` shows all 22 flits in order, first at cycle +2, contiguous.
  - `fcount`=22; `oerr`=0.
- **Fairness.** Ports 0, 1, 3 each hold a HEAD continuously.
  - Grant order is 0, 1, 3, 0; no packet interleaves.
  - One idle cycle appears after each TAIL.
- **Backpressure.** Pull `oready`=0 for 5 cycles mid-packet.
  - `odata` is stable; `iready`=0.
  - No flit is lost or duplicated; `fcount` is unchanged during the stall.
- **External select.** RR_MODE=0, `sel`=1, and ports 0 and 1 both present a HEAD.
  - Only port 1 is granted.
  - `sel`=5 with N=4 grants nothing.
- **Counter.** Preload `fcount` to all-ones-1 and send 3 flits: the count saturates at 0xFFFF.
  - `cnt_clr` together with a transfer gives 0.
- **Errors and reset.**
  - A NONE flit consumed in LOCK sets `oerr`=1.
  - Asserting `rst_` mid-packet gives `ovalid`=0 and state IDLE; port 0 wins the next arbitration.

Source files
------------

// File: rtl/mux_rr_n.sv
// mux_rr_n: N:1 flit multiplexer that locks the output to one input for a whole packet
// (HEAD..TAIL), with round-robin or external-select arbitration and a registered output.
module mux_rr_n #(
   parameter int N       = 4,
   parameter int DATAW   = 66,
   parameter int VCHW    = 2,
   parameter int PSELW   = $clog2(N),
   parameter bit RR_MODE = 1'b1,
   parameter int CNTW    = 16
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic [N*DATAW-1:0]  idata,
   input  logic [N-1:0]        ivalid,
   input  logic [N*VCHW-1:0]   ivch,
   output logic [N-1:0]        iready,
   input  logic [PSELW-1:0]    sel,
   output logic [DATAW-1:0]    odata,
   output logic                ovalid,
   output logic [VCHW-1:0]     ovch,
   input  logic                oready,
   input  logic                cnt_clr,
   output logic [CNTW-1:0]     fcount,
   output logic                oerr,
   output logic                dbg_state,
   output logic [PSELW-1:0]    dbg_grant
);

   // Handshake: a flit moves on a port in any cycle where its valid and ready are both
   // high at the rising edge; ready never depends on a flit that has not been offered.

   localparam logic [1:0] T_NONE = 2'b00;
   localparam logic [1:0] T_HEAD = 2'b01;
   localparam logic [1:0] T_TAIL = 2'b10;
   localparam logic [PSELW-1:0] LAST_RST = PSELW'(N - 1);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [PSELW-1:0]  grant, grant_nxt;
   logic [PSELW-1:0]  last, last_nxt;
   logic              first, first_nxt;
   logic              err_evt;

   logic [N-1:0]      elig;
   logic              arb_hit;
   logic [PSELW-1:0]  arb_port;

   logic              g_valid;
   logic [DATAW-1:0]  g_data;
   logic [VCHW-1:0]   g_vch;
   logic [1:0]        g_type;
   logic              take;

   always_comb begin
      elig = '0;
      for (int k = 0; k < N; k++) begin
         elig[k] = ivalid[k] & (idata[k*DATAW + DATAW - 2 +: 2] == T_HEAD);
      end
   end

   // Round-robin scans last+1, last+2, ... so the most recent winner has lowest priority.
   always_comb begin
      arb_hit  = 1'b0;
      arb_port = '0;
      if (RR_MODE) begin
         for (int i = 1; i <= N; i++) begin
            for (int k = 0; k < N; k++) begin
               if (!arb_hit && (k == (int'(last) + i) % N) && elig[k]) begin
                  arb_hit  = 1'b1;
                  arb_port = PSELW'(k);
               end
            end
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if ((sel == PSELW'(k)) && elig[k]) begin
               arb_hit  = 1'b1;
               arb_port = PSELW'(k);
            end
         end
      end
   end

   always_comb begin
      g_valid = 1'b0;
      g_data  = '0;
      g_vch   = '0;
      for (int k = 0; k < N; k++) begin
         if (grant == PSELW'(k)) begin
            g_valid = ivalid[k];
            g_data  = idata[k*DATAW +: DATAW];
            g_vch   = ivch[k*VCHW +: VCHW];
         end
      end
   end

   assign g_type = g_data[DATAW-1 -: 2];
   assign take   = (state == LOCK) & g_valid & (~ovalid | oready);

   always_comb begin
      iready = '0;
      for (int k = 0; k < N; k++) begin
         iready[k] = take & (grant == PSELW'(k));
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      last_nxt  = last;
      first_nxt = first;
      err_evt   = 1'b0;
      case (state)
         IDLE: begin
            if (arb_hit) begin
               state_nxt = LOCK;
               grant_nxt = arb_port;
               first_nxt = 1'b1;
            end
         end
         LOCK: begin
            if (take) begin
               first_nxt = 1'b0;
               if ((g_type == T_NONE) || ((g_type == T_HEAD) && !first)) begin
                  err_evt = 1'b1;
               end
               if (g_type == T_TAIL) begin
                  state_nxt = IDLE;
                  last_nxt  = grant;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= IDLE;
         grant <= '0;
         last  <= LAST_RST;
         first <= 1'b0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         last  <= last_nxt;
         first <= first_nxt;
      end
   end

   // A consume always reloads the register, even when the held flit leaves this same edge.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         ovalid <= 1'b0;
         odata  <= '0;
         ovch   <= '0;
      end else if (take) begin
         ovalid <= 1'b1;
         odata  <= g_data;
         ovch   <= g_vch;
      end else if (oready) begin
         ovalid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         fcount <= '0;
      end else if (cnt_clr) begin
         fcount <= '0;
      end else if (ovalid && oready && (fcount != '1)) begin
         fcount <= fcount + CNTW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         oerr <= 1'b0;
      end else if (err_evt) begin
         oerr <= 1'b1;
      end
   end

   assign dbg_state = (state == LOCK);
   assign dbg_grant = grant;

endmodule

// File: tb/tb_mux_rr_n.sv
// Bench for mux_rr_n: per-port flit feeders, an output monitor popping an expected queue,
// and directed scenarios for latency, fairness, backpressure, select, counter and errors.
module tb_mux_rr_n;

   localparam int N       = 4;
   localparam int DATAW   = 66;
   localparam int VCHW    = 2;
   localparam int PSELW   = 2;
   localparam int PSELW_B = 3;
   localparam int CNTW    = 16;
   localparam int CNTW_B  = 3;
   localparam int EW      = VCHW + DATAW;
   localparam logic [1:0] T_NONE = 2'b00;
   localparam logic [1:0] T_HEAD = 2'b01;
   localparam logic [1:0] T_TAIL = 2'b10;
   localparam logic [1:0] T_DATA = 2'b11;

   logic                clk = 1'b0;
   logic                rst_;
   logic [N*DATAW-1:0]  idata;
   logic [N-1:0]        ivalid;
   logic [N*VCHW-1:0]   ivch;
   logic                oready;
   logic                cnt_clr;
   logic [PSELW-1:0]    sel_a;
   logic [PSELW_B-1:0]  sel_b;

   logic [N-1:0]        iready_a, iready_b;
   logic [DATAW-1:0]    odata_a, odata_b;
   logic                ovalid_a, ovalid_b;
   logic [VCHW-1:0]     ovch_a, ovch_b;
   logic [CNTW-1:0]     fcount_a;
   logic [CNTW_B-1:0]   fcount_b;
   logic                oerr_a, oerr_b;
   logic                dbg_state_a, dbg_state_b;
   logic [PSELW-1:0]    dbg_grant_a;
   logic [PSELW_B-1:0]  dbg_grant_b;

   logic [EW-1:0]       port_q [N][$];
   logic [EW-1:0]       exp_q[$];
   int                  out_cyc_q[$];
   int                  n_cmp = 0;
   int                  n_fail = 0;
   int                  cyc = 0;
   int                  exp_fc = 0;
   bit                  use_b = 1'b0;
   logic [N-1:0]        cons = '0;
   logic [N-1:0]        cons_seen = '0;

   logic [N-1:0]        cur_iready;
   logic [DATAW-1:0]    cur_odata;
   logic [VCHW-1:0]     cur_ovch;
   logic                cur_ovalid;
   int                  fc_max;

   assign cur_iready = use_b ? iready_b : iready_a;
   assign cur_odata  = use_b ? odata_b : odata_a;
   assign cur_ovch   = use_b ? ovch_b : ovch_a;
   assign cur_ovalid = use_b ? ovalid_b : ovalid_a;
   assign fc_max     = use_b ? 7 : 65535;

   mux_rr_n #(.N(N), .DATAW(DATAW), .VCHW(VCHW), .PSELW(PSELW), .RR_MODE(1'b1), .CNTW(CNTW)) dut_a (
      .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(iready_a),
      .sel(sel_a), .odata(odata_a), .ovalid(ovalid_a), .ovch(ovch_a), .oready(oready),
      .cnt_clr(cnt_clr), .fcount(fcount_a), .oerr(oerr_a), .dbg_state(dbg_state_a),
      .dbg_grant(dbg_grant_a)
   );

   mux_rr_n #(.N(N), .DATAW(DATAW), .VCHW(VCHW), .PSELW(PSELW_B), .RR_MODE(1'b0), .CNTW(CNTW_B)) dut_b (
      .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(iready_b),
      .sel(sel_b), .odata(odata_b), .ovalid(ovalid_b), .ovch(ovch_b), .oready(oready),
      .cnt_clr(cnt_clr), .fcount(fcount_b), .oerr(oerr_b), .dbg_state(dbg_state_b),
      .dbg_grant(dbg_grant_b)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, summary not printed");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic [1:0] t, input int p, input int pkt, input int idx);
      logic [DATAW-1:0] d;
      d = '0;
      d[DATAW-1 -: 2] = t;
      d[31:0]  = {8'(p), 8'(pkt), 16'(idx)};
      d[63:32] = ~{8'(p), 8'(pkt), 16'(idx)};
      return {VCHW'(p + pkt), d};
   endfunction

   // driver tasks
   task automatic load_flit(input int p, input logic [1:0] t, input int pkt, input int idx);
      port_q[p].push_back(mk(t, p, pkt, idx));
      exp_q.push_back(mk(t, p, pkt, idx));
   endtask

   task automatic load_pkt(input int p, input int pkt, input int len, input bit exp_now);
      logic [1:0] t;
      for (int i = 0; i < len; i++) begin
         t = (i == 0) ? T_HEAD : ((i == len - 1) ? T_TAIL : T_DATA);
         port_q[p].push_back(mk(t, p, pkt, i));
         if (exp_now) exp_q.push_back(mk(t, p, pkt, i));
      end
   endtask

   task automatic expect_pkt(input int p, input int pkt, input int len);
      logic [1:0] t;
      for (int i = 0; i < len; i++) begin
         t = (i == 0) ? T_HEAD : ((i == len - 1) ? T_TAIL : T_DATA);
         exp_q.push_back(mk(t, p, pkt, i));
      end
   endtask

   task automatic flush();
      for (int p = 0; p < N; p++) port_q[p].delete();
      exp_q.delete();
      out_cyc_q.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_ = 1'b0;
      @(negedge clk); #1;
      flush();
      @(posedge clk); #1;
      rst_ = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || cur_ovalid) && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      n_cmp++;
      if (exp_q.size() != 0 || cur_ovalid) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d flits outstanding, required 0", name, exp_q.size());
      end
   endtask

   task automatic wait_outs(input string name, input int n, input int budget);
      int k;
      k = 0;
      while (out_cyc_q.size() < n && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      n_cmp++;
      if (out_cyc_q.size() < n) begin
         n_fail++;
         $display("FAIL %s_outs: got %0d outputs, required %0d", name, out_cyc_q.size(), n);
      end
   endtask

   // feeders: present each port's queue head, pop it after the edge that consumed it
   initial begin : sampler
      forever begin
         @(negedge clk);
         cons = ivalid & cur_iready;
         cons_seen = cons_seen | cons;
      end
   end

   initial begin : feeder
      logic [EW-1:0] f;
      ivalid = '0;
      idata  = '0;
      ivch   = '0;
      forever begin
         @(posedge clk); #1;
         for (int p = 0; p < N; p++) begin
            if (cons[p] && port_q[p].size() != 0) f = port_q[p].pop_front();
            if (port_q[p].size() != 0) begin
               f = port_q[p][0];
               ivalid[p] = 1'b1;
               idata[p*DATAW +: DATAW] = f[DATAW-1:0];
               ivch[p*VCHW +: VCHW] = f[EW-1:DATAW];
            end else begin
               ivalid[p] = 1'b0;
            end
         end
      end
   end

   // scoreboard monitor
   initial begin : monitor
      logic [EW-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst_) begin
            exp_fc = 0;
         end else begin
            if (cur_ovalid && oready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL out_flit: got %0h required no flit", {cur_ovch, cur_odata});
               end else begin
                  e = exp_q.pop_front();
                  check("out_flit", {cur_ovch, cur_odata}, e);
               end
               out_cyc_q.push_back(cyc);
            end
            if (cnt_clr) exp_fc = 0;
            else if (cur_ovalid && oready && exp_fc < fc_max) exp_fc++;
         end
      end
   end

   initial begin : stim
      int t0;
      oready  = 1'b1;
      cnt_clr = 1'b0;
      sel_a   = '0;
      sel_b   = '0;
      rst_    = 1'b1;
      #2 rst_ = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("rst_ovalid", ovalid_a, 0);
      check("rst_odata", odata_a, 0);
      check("rst_ovch", ovch_a, 0);
      check("rst_iready", iready_a, 0);
      check("rst_fcount", fcount_a, 0);
      check("rst_oerr", oerr_a, 0);
      check("rst_state", dbg_state_a, 0);
      check("rst_grant", dbg_grant_a, 0);
      @(posedge clk); #1;
      rst_ = 1'b1;

      // single-port packet from port 2
      @(posedge clk); #2;
      flush();
      t0 = cyc + 1;
      load_pkt(2, 1, 22, 1'b1);
      wait_drain("single", 100);
      check("single_count", out_cyc_q.size(), 22);
      if (out_cyc_q.size() == 22) begin
         check("single_latency", out_cyc_q[0] - t0, 2);
         check("single_contig", out_cyc_q[21] - out_cyc_q[0], 21);
      end
      check("single_fcount", fcount_a, 22);
      check("single_oerr", oerr_a, 0);

      // fairness: expected grant order 0, 1, 3, 0 from reset
      do_reset();
      @(posedge clk); #2;
      load_pkt(0, 1, 4, 1'b0);
      load_pkt(0, 2, 4, 1'b0);
      load_pkt(1, 1, 4, 1'b0);
      load_pkt(3, 1, 4, 1'b0);
      expect_pkt(0, 1, 4);
      expect_pkt(1, 1, 4);
      expect_pkt(3, 1, 4);
      expect_pkt(0, 2, 4);
      wait_drain("fair", 200);
      check("fair_count", out_cyc_q.size(), 16);
      if (out_cyc_q.size() == 16) begin
         for (int b = 1; b < 4; b++) check("fair_bubble", out_cyc_q[4*b] - out_cyc_q[4*b-1], 2);
      end
      check("fair_fcount", fcount_a, 16);

      // backpressure: 5 stalled cycles mid-packet
      @(posedge clk); #2;
      out_cyc_q.delete();
      load_pkt(2, 3, 12, 1'b1);
      wait_outs("bp", 4, 50);
      @(posedge clk); #1;
      oready = 1'b0;
      repeat (5) begin
         @(negedge clk); #1;
         check("bp_iready", iready_a, 0);
         check("bp_ovalid", ovalid_a, 1);
         if (exp_q.size() != 0) check("bp_hold", {ovch_a, odata_a}, exp_q[0]);
         check("bp_fcount", fcount_a, exp_fc);
      end
      @(posedge clk); #1;
      oready = 1'b1;
      wait_drain("bp", 100);
      check("bp_out_count", out_cyc_q.size(), 12);
      check("bp_fcount_end", fcount_a, 28);

      // NONE flit inside a packet
      @(posedge clk); #2;
      load_flit(1, T_HEAD, 4, 0);
      load_flit(1, T_NONE, 4, 1);
      load_flit(1, T_TAIL, 4, 2);
      wait_drain("none", 50);
      check("none_oerr", oerr_a, 1);

      // second HEAD inside a packet
      do_reset();
      @(negedge clk); #1;
      check("rst_clears_oerr", oerr_a, 0);
      @(posedge clk); #2;
      load_flit(2, T_HEAD, 5, 0);
      load_flit(2, T_DATA, 5, 1);
      load_flit(2, T_HEAD, 5, 2);
      load_flit(2, T_TAIL, 5, 3);
      wait_drain("head2", 50);
      check("head2_oerr", oerr_a, 1);
      check("head2_fcount", fcount_a, exp_fc);

      // reset mid-packet, then port 0 must win over port 3
      @(posedge clk); #2;
      out_cyc_q.delete();
      load_pkt(1, 6, 10, 1'b1);
      wait_outs("midrst", 3, 50);
      @(posedge clk); #1;
      rst_ = 1'b0;
      @(negedge clk); #1;
      check("midrst_ovalid", ovalid_a, 0);
      check("midrst_state", dbg_state_a, 0);
      check("midrst_iready", iready_a, 0);
      check("midrst_oerr", oerr_a, 0);
      check("midrst_fcount", fcount_a, 0);
      flush();
      @(posedge clk); #1;
      rst_ = 1'b1;
      @(posedge clk); #2;
      load_pkt(3, 7, 3, 1'b0);
      load_pkt(0, 7, 3, 1'b0);
      expect_pkt(0, 7, 3);
      expect_pkt(3, 7, 3);
      wait_drain("midrst_arb", 50);

      // external select on the second instance
      @(posedge clk); #1;
      use_b = 1'b1;
      sel_b = 3'd1;
      do_reset();
      @(posedge clk); #2;
      cons_seen = '0;
      load_pkt(0, 8, 3, 1'b0);
      load_pkt(1, 8, 3, 1'b1);
      wait_drain("sel1", 50);
      check("sel1_port0_untouched", cons_seen[0], 0);
      check("sel1_port0_left", port_q[0].size(), 3);
      sel_b = 3'd5;
      repeat (6) @(negedge clk);
      #1;
      check("sel5_state", dbg_state_b, 0);
      check("sel5_no_out", out_cyc_q.size(), 3);
      check("sel5_no_consume", cons_seen[0], 0);
      expect_pkt(0, 8, 3);
      sel_b = 3'd0;
      wait_drain("sel0", 50);
      check("sel_fcount6", fcount_b, 6);

      // counter saturation and clear
      sel_b = 3'd2;
      load_pkt(2, 9, 3, 1'b1);
      wait_drain("sat", 50);
      check("sat_fcount", fcount_b, 7);
      check("sat_model", fcount_b, exp_fc);
      out_cyc_q.delete();
      sel_b = 3'd3;
      load_pkt(3, 9, 4, 1'b1);
      wait_outs("clr", 1, 50);
      @(posedge clk); #1;
      cnt_clr = 1'b1;
      @(negedge clk); #1;
      check("clr_xfer", ovalid_b, 1);
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      @(negedge clk); #1;
      check("clr_fcount0", fcount_b, 0);
      wait_drain("clr", 50);
      check("clr_fcount_end", fcount_b, 2);
      check("clr_model", fcount_b, exp_fc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
